// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared pipeline constants, forwarding encodings and scoreboard helpers
package reg_scoreboard_pkg;
  localparam int NUM_REGS     = 32;
  localparam int REG_W        = 5;
  localparam int MAX_LONG_DEF = 4;
  typedef logic [REG_W-1:0]    reg_idx_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;
  function automatic reg_mask_t reg_onehot(input reg_idx_t r);
    return reg_mask_t'(1) << r;
  endfunction
endpackage

// File: rtl/reg_scoreboard_hazard_cmp.sv
// sb_hazard_cmp: combinational compare of ID-stage sources/dest against the busy mask and load tracker
module sb_hazard_cmp
  import reg_scoreboard_pkg::*;
(
  input  logic                uses_rs,
  input  logic [REG_W-1:0]    rs,
  input  logic                uses_rt,
  input  logic [REG_W-1:0]    rt,
  input  logic                reg_write,
  input  logic [REG_W-1:0]    rd,
  input  logic                is_long,
  input  logic                full,
  input  logic                ld_v,
  input  logic [REG_W-1:0]    ld_rd,
  input  logic [NUM_REGS-1:0] mask,
  output logic                ld_use,
  output logic                raw,
  output logic                waw,
  output logic                structural
);
  logic rs_live, rt_live;
  always_comb begin
    rs_live    = uses_rs && rs != '0;
    rt_live    = uses_rt && rt != '0;
    ld_use     = ld_v && ld_rd != '0 && ((rs_live && rs == ld_rd) || (rt_live && rt == ld_rd));
    raw        = (rs_live && mask[rs]) || (rt_live && mask[rt]);
    waw        = reg_write && rd != '0 && mask[rd];
    structural = is_long && full;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: ID-stage interlock for load-use and long-latency (mul/div) register hazards
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_LONG = MAX_LONG_DEF,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rs,
  input  logic [REG_W-1:0]    issue_rt,
  input  logic                issue_uses_rs,
  input  logic                issue_uses_rt,
  input  logic                issue_RegWrite,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic                issue_is_load,
  input  logic                issue_is_long,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    outstanding,
  output logic                wb_err
);
  if (CNT_W < $clog2(MAX_LONG + 1)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for MAX_LONG");
  end

  logic [NUM_REGS-1:0] busy_q, busy_d, mask_eff, clr_vec, set_vec;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                ld_v_q, ld_v_d, wb_err_q, wb_err_d;
  logic [REG_W-1:0]    ld_rd_q, ld_rd_d;
  logic                wb_clr, long_set, accept, full;
  logic                hz_ld_use, hz_raw, hz_waw, hz_struct;

  // A completing write is visible to this cycle's checks, giving zero-bubble wakeup
  always_comb begin
    wb_clr   = wb_valid && wb_rd != '0 && busy_q[wb_rd];
    clr_vec  = wb_clr ? reg_onehot(wb_rd) : '0;
    mask_eff = busy_q & ~clr_vec;
    full     = outstanding_q == CNT_W'(MAX_LONG);
  end

  sb_hazard_cmp u_cmp (
    .uses_rs    (issue_uses_rs),
    .rs         (issue_rs),
    .uses_rt    (issue_uses_rt),
    .rt         (issue_rt),
    .reg_write  (issue_RegWrite),
    .rd         (issue_rd),
    .is_long    (issue_is_long),
    .full       (full),
    .ld_v       (ld_v_q),
    .ld_rd      (ld_rd_q),
    .mask       (mask_eff),
    .ld_use     (hz_ld_use),
    .raw        (hz_raw),
    .waw        (hz_waw),
    .structural (hz_struct)
  );

  always_comb begin
    stall         = issue_valid && (hz_ld_use || hz_raw || hz_waw || hz_struct);
    accept        = issue_valid && !stall && !flush;
    long_set      = accept && issue_is_long && issue_RegWrite && issue_rd != '0;
    set_vec       = long_set ? reg_onehot(issue_rd) : '0;
    busy_d        = mask_eff | set_vec;
    outstanding_d = outstanding_q + CNT_W'(long_set) - CNT_W'(wb_clr);
    ld_v_d        = accept && issue_is_load && issue_RegWrite && issue_rd != '0;
    ld_rd_d       = issue_rd;
    wb_err_d      = wb_err_q || (wb_valid && !wb_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      ld_v_q        <= 1'b0;
      ld_rd_q       <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      ld_v_q        <= ld_v_d;
      ld_rd_q       <= ld_rd_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign busy_mask   = busy_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed-vector bench for the register scoreboard
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_uses_rs, issue_uses_rt, issue_RegWrite;
  logic [4:0]  issue_rs, issue_rt, issue_rd, wb_rd;
  logic        issue_is_load, issue_is_long, flush, wb_valid;
  logic        stall, wb_err;
  logic [31:0] busy_mask;
  logic [2:0]  outstanding;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt), .issue_RegWrite(issue_RegWrite),
    .issue_rd(issue_rd), .issue_is_load(issue_is_load), .issue_is_long(issue_is_long), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall), .busy_mask(busy_mask),
    .outstanding(outstanding), .wb_err(wb_err)
  );

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_uses_rs = 0; issue_uses_rt = 0;
    issue_RegWrite = 0; issue_rd = 0; issue_is_load = 0; issue_is_long = 0; flush = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic rw, input logic [4:0] rd, input logic ld, input logic lg);
    issue_valid = 1; issue_rs = rs; issue_uses_rs = urs; issue_rt = rt; issue_uses_rt = urt;
    issue_RegWrite = rw; issue_rd = rd; issue_is_load = ld; issue_is_long = lg;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    @(negedge clk);
    issue(0, 0, 0, 0, 1, 3, 0, 1);
    wb(3);
    #1;
    vectors++;
    if (stall !== 1'b0 || busy_mask !== 32'h0 || outstanding !== 3'd0 || wb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: stall=%b busy=%h out=%0d err=%b, need 0/0/0/0", stall, busy_mask, outstanding, wb_err);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (busy_mask !== 32'h0 || wb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ignores_wb: busy=%h err=%b, need 0/0", busy_mask, wb_err);
    end
    idle();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    issue(0, 0, 0, 0, 1, 5, 1, 0);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL load_issue: stall=%b need 0", stall); end
    @(negedge clk);
    issue(5, 1, 6, 1, 1, 8, 0, 0);
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL load_use_stall: stall=%b need 1", stall); end
    @(negedge clk);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_release: stall=%b need 0", stall); end
    @(negedge clk);
    idle();
    issue(6, 1, 5, 1, 1, 8, 0, 0);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_rt_after: stall=%b need 0", stall); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_long_raw();
    @(negedge clk);
    issue(0, 0, 0, 0, 1, 7, 0, 1);
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (busy_mask !== 32'h80 || outstanding !== 3'd1) begin
      miscompares++; $display("FAIL long_set: busy=%h out=%0d, need 00000080/1", busy_mask, outstanding);
    end
    issue(1, 0, 7, 1, 1, 9, 0, 0);
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL raw_stall: stall=%b need 1", stall); end
    @(negedge clk);
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL raw_hold: stall=%b need 1", stall); end
    @(negedge clk);
    wb(7);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL raw_wakeup: stall=%b need 0", stall); end
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (busy_mask !== 32'h0 || outstanding !== 3'd0 || wb_err !== 1'b0) begin
      miscompares++; $display("FAIL long_clear: busy=%h out=%0d err=%b, need 0/0/0", busy_mask, outstanding, wb_err);
    end
  endtask

  task automatic test_structural();
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      issue(0, 0, 0, 0, 1, 5'(r), 0, 1);
      #1;
      vectors++;
      if (stall !== 1'b0) begin miscompares++; $display("FAIL long_fill_%0d: stall=%b need 0", r, stall); end
    end
    @(negedge clk);
    issue(0, 0, 0, 0, 1, 3, 0, 0);
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL waw_stall: stall=%b need 1", stall); end
    issue(0, 0, 0, 0, 1, 5, 0, 1);
    #1;
    vectors++;
    if (stall !== 1'b1 || outstanding !== 3'd4 || busy_mask !== 32'h1E) begin
      miscompares++; $display("FAIL struct_full: stall=%b out=%0d busy=%h, need 1/4/0000001e", stall, outstanding, busy_mask);
    end
    @(negedge clk);
    wb(2);
    #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL struct_wb_cycle: stall=%b need 1", stall); end
    @(negedge clk);
    wb_valid = 0;
    #1;
    vectors++;
    if (stall !== 1'b0 || outstanding !== 3'd3) begin
      miscompares++; $display("FAIL struct_accept: stall=%b out=%0d, need 0/3", stall, outstanding);
    end
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (outstanding !== 3'd4 || busy_mask !== 32'h3A) begin
      miscompares++; $display("FAIL struct_after: out=%0d busy=%h, need 4/0000003a", outstanding, busy_mask);
    end
    for (int r = 1; r <= 5; r++) begin
      if (r != 2) begin
        wb(5'(r));
        @(negedge clk);
      end
    end
    idle();
    #1;
    vectors++;
    if (outstanding !== 3'd0 || busy_mask !== 32'h0 || wb_err !== 1'b0) begin
      miscompares++; $display("FAIL struct_drain: out=%0d busy=%h err=%b, need 0/0/0", outstanding, busy_mask, wb_err);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    issue(0, 0, 0, 0, 1, 9, 0, 1);
    @(negedge clk);
    idle();
    wb(9);
    issue(0, 0, 0, 0, 1, 9, 0, 1);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL same_cycle_stall: stall=%b need 0", stall); end
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (busy_mask !== 32'h200 || outstanding !== 3'd1) begin
      miscompares++; $display("FAIL same_cycle_state: busy=%h out=%0d, need 00000200/1", busy_mask, outstanding);
    end
    wb(9);
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (busy_mask !== 32'h0 || outstanding !== 3'd0) begin
      miscompares++; $display("FAIL same_cycle_drain: busy=%h out=%0d, need 0/0", busy_mask, outstanding);
    end
  endtask

  task automatic test_wb_err_r0();
    @(negedge clk);
    wb(12);
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if (wb_err !== 1'b1 || busy_mask !== 32'h0 || outstanding !== 3'd0) begin
      miscompares++; $display("FAIL wb_err_set: err=%b busy=%h out=%0d, need 1/0/0", wb_err, busy_mask, outstanding);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (wb_err !== 1'b1) begin miscompares++; $display("FAIL wb_err_sticky: err=%b need 1", wb_err); end
    issue(0, 0, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    issue(0, 1, 0, 1, 1, 4, 0, 0);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL r0_no_hazard: stall=%b need 0", stall); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_flush();
    @(negedge clk);
    issue(0, 0, 0, 0, 1, 10, 1, 0);
    @(negedge clk);
    idle();
    flush = 1;
    @(negedge clk);
    flush = 0;
    issue(10, 1, 0, 0, 1, 11, 0, 0);
    #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_kills_load: stall=%b need 0", stall); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      issue(0, 0, 0, 0, 1, 5'(r), 0, 1);
    end
    @(negedge clk);
    issue(1, 1, 0, 0, 1, 6, 0, 0);
    #1;
    vectors++;
    if (outstanding !== 3'd3 || busy_mask !== 32'hE || stall !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset: out=%0d busy=%h stall=%b, need 3/0000000e/1", outstanding, busy_mask, stall);
    end
    rst_n = 0;
    #1;
    vectors++;
    if (outstanding !== 3'd0 || busy_mask !== 32'h0 || stall !== 1'b0 || wb_err !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: out=%0d busy=%h stall=%b err=%b, need 0/0/0/0", outstanding, busy_mask, stall, wb_err);
    end
    wb(1);
    @(negedge clk);
    idle();
    rst_n = 1;
    @(negedge clk);
    #1;
    vectors++;
    if (wb_err !== 1'b0 || busy_mask !== 32'h0 || outstanding !== 3'd0) begin
      miscompares++; $display("FAIL post_reset: err=%b busy=%h out=%0d, need 0/0/0", wb_err, busy_mask, outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_long_raw();
    test_structural();
    test_same_cycle();
    test_wb_err_r0();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
